// File: rtl/regfile_pkg.sv
// Shared defaults and types for the register file with pending-write scoreboard.
// Contents: default geometry, register index type, data word type.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF   = 16;
    localparam int unsigned NUM_REGS_DEF = 16;
    localparam int unsigned ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
    typedef logic [DATA_W_DEF-1:0] data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one pending bit per register, set by a reservation,
// cleared by a write; a reservation wins over a same-cycle write to the same register.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   wr_en_i/addr_i   write strobe and address (clears pending)
//   rsv_i/addr_i     reserve strobe and address (sets pending)
//   pend_o           current pending vector (registered)
//   pend_next_c_o    next-state pending vector (combinational)
//   rsv_err_o        registered pulse: reservation hit an already-pending register
module regfile_scoreboard #(
    parameter int unsigned NUM_REGS = 16,
    parameter bit          ZERO_R0  = 1'b0,
    localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_en_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    input  logic                rsv_i,
    input  logic [ADDR_W-1:0]   rsv_addr_i,
    output logic [NUM_REGS-1:0] pend_o,
    output logic [NUM_REGS-1:0] pend_next_c_o,
    output logic                rsv_err_o
);

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;
    logic                rsv_err_q;
    logic                rsv_err_d;

    // Per-register next state; the reservation belongs to the newer producer.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pend
        localparam bit IS_R0 = ZERO_R0 && (g == 0);
        if (IS_R0) begin : g_zero
            assign pend_d[g] = 1'b0;
        end else begin : g_live
            assign pend_d[g] = (rsv_i && (rsv_addr_i == ADDR_W'(g)))
                             || (pend_q[g] && !(wr_en_i && (wr_addr_i == ADDR_W'(g))));
        end
    end

    // A hardwired R0 is never pending, so it can never raise an error.
    always_comb begin
        rsv_err_d = 1'b0;
        if (rsv_i && pend_q[rsv_addr_i] && !(wr_en_i && (wr_addr_i == rsv_addr_i))) begin
            rsv_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q    <= '0;
            rsv_err_q <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            rsv_err_q <= rsv_err_d;
        end
    end

    assign pend_o        = pend_q;
    assign pend_next_c_o = pend_d;
    assign rsv_err_o     = rsv_err_q;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file: one write port, two registered read ports,
// optional write-to-read bypass, optional hardwired-zero R0, pending-write scoreboard.
// Ports:
//   Clk, Rst                     clock, synchronous active-high reset
//   RdestRegLoc, RsrcRegLoc      read port A / B addresses
//   WrRegLoc, En, Load           write address, enable, data
//   Rsv, RsvRegLoc               reserve strobe and address
//   RdestOut, RsrcOut            registered read data A / B
//   RdestBusy, RsrcBusy          registered pending flags A / B
//   RsvErr                       registered pulse: reservation of a pending register
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_R0  = 1'b0,
    localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] RdestRegLoc,
    input  logic [ADDR_W-1:0] RsrcRegLoc,
    input  logic [ADDR_W-1:0] WrRegLoc,
    input  logic              En,
    input  logic [DATA_W-1:0] Load,
    input  logic              Rsv,
    input  logic [ADDR_W-1:0] RsvRegLoc,
    output logic [DATA_W-1:0] RdestOut,
    output logic [DATA_W-1:0] RsrcOut,
    output logic              RdestBusy,
    output logic              RsrcBusy,
    output logic              RsvErr
);

    logic [DATA_W-1:0]   mem_q     [NUM_REGS];
    logic [DATA_W-1:0]   mem_d     [NUM_REGS];
    logic [DATA_W-1:0]   rd_view   [NUM_REGS];
    logic [NUM_REGS-1:0] pend_cur;
    logic [NUM_REGS-1:0] pend_nxt;
    logic [NUM_REGS-1:0] busy_view;

    logic [DATA_W-1:0] rdest_q, rdest_d;
    logic [DATA_W-1:0] rsrc_q,  rsrc_d;
    logic              rdest_busy_q, rdest_busy_d;
    logic              rsrc_busy_q,  rsrc_busy_d;

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ZERO_R0  (ZERO_R0)
    ) u_sb (
        .clk_i         (Clk),
        .rst_i         (Rst),
        .wr_en_i       (En),
        .wr_addr_i     (WrRegLoc),
        .rsv_i         (Rsv),
        .rsv_addr_i    (RsvRegLoc),
        .pend_o        (pend_cur),
        .pend_next_c_o (pend_nxt),
        .rsv_err_o     (RsvErr)
    );

    // Write decode per register; the read view is post-edge state with bypass, pre-edge without.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        localparam bit IS_R0 = ZERO_R0 && (g == 0);
        if (IS_R0) begin : g_zero
            assign mem_d[g] = '0;
        end else begin : g_live
            assign mem_d[g] = (En && (WrRegLoc == ADDR_W'(g))) ? Load : mem_q[g];
        end
        assign rd_view[g]   = BYPASS ? mem_d[g]    : mem_q[g];
        assign busy_view[g] = BYPASS ? pend_nxt[g] : pend_cur[g];
    end

    // Read muxes feeding the output registers.
    always_comb begin
        rdest_d      = rd_view[RdestRegLoc];
        rsrc_d       = rd_view[RsrcRegLoc];
        rdest_busy_d = busy_view[RdestRegLoc];
        rsrc_busy_d  = busy_view[RsrcRegLoc];
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                mem_q[i] <= '0;
            end
            rdest_q      <= '0;
            rsrc_q       <= '0;
            rdest_busy_q <= 1'b0;
            rsrc_busy_q  <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            rdest_q      <= rdest_d;
            rsrc_q       <= rsrc_d;
            rdest_busy_q <= rdest_busy_d;
            rsrc_busy_q  <= rsrc_busy_d;
        end
    end

    assign RdestOut  = rdest_q;
    assign RsrcOut   = rsrc_q;
    assign RdestBusy = rdest_busy_q;
    assign RsrcBusy  = rsrc_busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: five configurations driven by shared stimulus,
// each checked every cycle against an array-based model, plus literal expectations.
module tb_regfile_sb;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, rsv;
    logic [4:0]  ra, rb, wa, va;
    logic [31:0] ld;

    // Instances: 0 B1/Z0, 1 B0/Z0, 2 B1/Z1, 3 32x32 B1/Z0, 4 B0/Z1
    logic [15:0] oa16 [4];
    logic [15:0] ob16 [4];
    logic [31:0] oa32, ob32;
    logic        dba [5];
    logic        dbb [5];
    logic        derr [5];
    logic [31:0] dut_a [5];
    logic [31:0] dut_b [5];

    regfile_sb #(.DATA_W(16), .NUM_REGS(16), .BYPASS(1'b1), .ZERO_R0(1'b0)) u0 (
        .Clk(clk), .Rst(rst), .RdestRegLoc(ra[3:0]), .RsrcRegLoc(rb[3:0]),
        .WrRegLoc(wa[3:0]), .En(en), .Load(ld[15:0]), .Rsv(rsv), .RsvRegLoc(va[3:0]),
        .RdestOut(oa16[0]), .RsrcOut(ob16[0]), .RdestBusy(dba[0]), .RsrcBusy(dbb[0]),
        .RsvErr(derr[0]));
    regfile_sb #(.DATA_W(16), .NUM_REGS(16), .BYPASS(1'b0), .ZERO_R0(1'b0)) u1 (
        .Clk(clk), .Rst(rst), .RdestRegLoc(ra[3:0]), .RsrcRegLoc(rb[3:0]),
        .WrRegLoc(wa[3:0]), .En(en), .Load(ld[15:0]), .Rsv(rsv), .RsvRegLoc(va[3:0]),
        .RdestOut(oa16[1]), .RsrcOut(ob16[1]), .RdestBusy(dba[1]), .RsrcBusy(dbb[1]),
        .RsvErr(derr[1]));
    regfile_sb #(.DATA_W(16), .NUM_REGS(16), .BYPASS(1'b1), .ZERO_R0(1'b1)) u2 (
        .Clk(clk), .Rst(rst), .RdestRegLoc(ra[3:0]), .RsrcRegLoc(rb[3:0]),
        .WrRegLoc(wa[3:0]), .En(en), .Load(ld[15:0]), .Rsv(rsv), .RsvRegLoc(va[3:0]),
        .RdestOut(oa16[2]), .RsrcOut(ob16[2]), .RdestBusy(dba[2]), .RsrcBusy(dbb[2]),
        .RsvErr(derr[2]));
    regfile_sb #(.DATA_W(32), .NUM_REGS(32), .BYPASS(1'b1), .ZERO_R0(1'b0)) u3 (
        .Clk(clk), .Rst(rst), .RdestRegLoc(ra), .RsrcRegLoc(rb),
        .WrRegLoc(wa), .En(en), .Load(ld), .Rsv(rsv), .RsvRegLoc(va),
        .RdestOut(oa32), .RsrcOut(ob32), .RdestBusy(dba[3]), .RsrcBusy(dbb[3]),
        .RsvErr(derr[3]));
    regfile_sb #(.DATA_W(16), .NUM_REGS(16), .BYPASS(1'b0), .ZERO_R0(1'b1)) u4 (
        .Clk(clk), .Rst(rst), .RdestRegLoc(ra[3:0]), .RsrcRegLoc(rb[3:0]),
        .WrRegLoc(wa[3:0]), .En(en), .Load(ld[15:0]), .Rsv(rsv), .RsvRegLoc(va[3:0]),
        .RdestOut(oa16[3]), .RsrcOut(ob16[3]), .RdestBusy(dba[4]), .RsrcBusy(dbb[4]),
        .RsvErr(derr[4]));

    always_comb begin
        dut_a[0] = 32'(oa16[0]); dut_b[0] = 32'(ob16[0]);
        dut_a[1] = 32'(oa16[1]); dut_b[1] = 32'(ob16[1]);
        dut_a[2] = 32'(oa16[2]); dut_b[2] = 32'(ob16[2]);
        dut_a[3] = oa32;         dut_b[3] = ob32;
        dut_a[4] = 32'(oa16[3]); dut_b[4] = 32'(ob16[3]);
    end

    // Configuration table for the model.
    int          nr    [5] = '{16, 16, 16, 32, 16};
    logic [31:0] dmask [5] = '{32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF_FFFF, 32'hFFFF};
    bit          byp   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    bit          zr    [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    logic [31:0] mm [5][32];
    bit          pp [5][32];
    logic [31:0] ea [5];
    logic [31:0] eb [5];
    bit          eba [5];
    bit          ebb [5];
    bit          eerr [5];
    bit          started = 1'b0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mdata(input int k, input int adr);
        return (zr[k] && adr == 0) ? 32'h0 : mm[k][adr];
    endfunction

    function automatic bit mbusy(input int k, input int adr);
        return (zr[k] && adr == 0) ? 1'b0 : pp[k][adr];
    endfunction

    // Model: apply the clock-edge rules to the register arrays; reads take
    // the pre-edge view without bypass and the post-edge view with it.
    always @(posedge clk) begin
        for (int k = 0; k < 5; k++) begin
            int  w, r, a, b;
            bit  wok, rok;
            w = int'(wa) % nr[k];
            r = int'(va) % nr[k];
            a = int'(ra) % nr[k];
            b = int'(rb) % nr[k];
            if (rst) begin
                for (int j = 0; j < 32; j++) begin
                    mm[k][j] = 32'h0;
                    pp[k][j] = 1'b0;
                end
                ea[k] = 32'h0; eb[k] = 32'h0; eba[k] = 1'b0; ebb[k] = 1'b0; eerr[k] = 1'b0;
            end else begin
                wok = en && !(zr[k] && w == 0);
                rok = rsv && !(zr[k] && r == 0);
                eerr[k] = rok && pp[k][r] && !(wok && w == r);
                if (!byp[k]) begin
                    ea[k] = mdata(k, a); eb[k] = mdata(k, b);
                    eba[k] = mbusy(k, a); ebb[k] = mbusy(k, b);
                end
                if (wok) begin
                    mm[k][w] = ld & dmask[k];
                    pp[k][w] = 1'b0;
                end
                if (rok) pp[k][r] = 1'b1;
                if (byp[k]) begin
                    ea[k] = mdata(k, a); eb[k] = mdata(k, b);
                    eba[k] = mbusy(k, a); ebb[k] = mbusy(k, b);
                end
            end
        end
        started = 1'b1;
    end

    // Compare every output of every instance on the falling edge.
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("i%0d_rdest", k), dut_a[k], ea[k]);
                chk($sformatf("i%0d_rsrc", k), dut_b[k], eb[k]);
                chk($sformatf("i%0d_rdest_busy", k), 32'(dba[k]), 32'(eba[k]));
                chk($sformatf("i%0d_rsrc_busy", k), 32'(dbb[k]), 32'(ebb[k]));
                chk($sformatf("i%0d_rsv_err", k), 32'(derr[k]), 32'(eerr[k]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; en = 1'b0; rsv = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; rsv = 1'b0;
        ra = '0; rb = '0; wa = '0; va = '0; ld = '0;
        step();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("lit_reset_a%0d", k), dut_a[k], 32'h0);
            chk($sformatf("lit_reset_err%0d", k), 32'(derr[k]), 32'h0);
        end

        // Basic write then read on both ports.
        idle(); en = 1'b1; wa = 5'd3; ld = 32'h1234; step();
        wa = 5'd7; ld = 32'hBEEF; step();
        idle(); ra = 5'd3; rb = 5'd7; step();
        chk("lit_basic_a0", dut_a[0], 32'h1234);
        chk("lit_basic_b0", dut_b[0], 32'hBEEF);
        chk("lit_basic_a1", dut_a[1], 32'h1234);
        chk("lit_basic_b3", dut_b[3], 32'hBEEF);
        chk("lit_basic_busy0", 32'(dba[0]), 32'h0);

        // Same-cycle write and read: bypass vs. one-edge-late.
        en = 1'b1; wa = 5'd5; ld = 32'hA5A5; ra = 5'd5; rb = 5'd5; step();
        chk("lit_byp_a0", dut_a[0], 32'hA5A5);
        chk("lit_byp_b0", dut_b[0], 32'hA5A5);
        chk("lit_nobyp_a1", dut_a[1], 32'h0);
        idle(); step();
        chk("lit_nobyp_late_a1", dut_a[1], 32'hA5A5);

        // Reserve, double reserve, then write to release.
        rsv = 1'b1; va = 5'd9; ra = 5'd9; rb = 5'd9; step();
        chk("lit_rsv_busy0", 32'(dba[0]), 32'h1);
        chk("lit_rsv_busy1", 32'(dba[1]), 32'h0);
        chk("lit_rsv_noerr0", 32'(derr[0]), 32'h0);
        step();
        chk("lit_rsv_err0", 32'(derr[0]), 32'h1);
        chk("lit_rsv_err1", 32'(derr[1]), 32'h1);
        chk("lit_rsv_busy1_late", 32'(dba[1]), 32'h1);
        idle(); step();
        chk("lit_rsv_err_pulse0", 32'(derr[0]), 32'h0);
        en = 1'b1; wa = 5'd9; ld = 32'h0042; step();
        chk("lit_rel_a0", dut_a[0], 32'h0042);
        chk("lit_rel_busy0", 32'(dba[0]), 32'h0);
        chk("lit_rel_busy1", 32'(dba[1]), 32'h1);
        idle(); step();
        chk("lit_rel_a1", dut_a[1], 32'h0042);
        chk("lit_rel_busy1_late", 32'(dba[1]), 32'h0);

        // Write and reserve the same register in one cycle.
        en = 1'b1; wa = 5'd2; ld = 32'h1111; rsv = 1'b1; va = 5'd2; ra = 5'd2; rb = 5'd2; step();
        chk("lit_wr_rsv_a0", dut_a[0], 32'h1111);
        chk("lit_wr_rsv_busy0", 32'(dba[0]), 32'h1);
        chk("lit_wr_rsv_err0", 32'(derr[0]), 32'h0);
        idle(); step();
        chk("lit_wr_rsv_a1", dut_a[1], 32'h1111);
        chk("lit_wr_rsv_busy1", 32'(dba[1]), 32'h1);

        // R0 write and reserve, hardwired zero vs. ordinary.
        en = 1'b1; wa = 5'd0; ld = 32'hFFFF; rsv = 1'b1; va = 5'd0; ra = 5'd0; rb = 5'd0; step();
        chk("lit_r0_a2", dut_a[2], 32'h0);
        chk("lit_r0_busy2", 32'(dba[2]), 32'h0);
        chk("lit_r0_a0", dut_a[0], 32'hFFFF);
        chk("lit_r0_busy0", 32'(dba[0]), 32'h1);
        en = 1'b0; step();
        chk("lit_r0_err0", 32'(derr[0]), 32'h1);
        chk("lit_r0_err2", 32'(derr[2]), 32'h0);
        chk("lit_r0_a4", dut_a[4], 32'h0);
        chk("lit_r0_a1", dut_a[1], 32'hFFFF);
        idle();

        // Fill, reserve R4, then reset with a concurrent write.
        for (int i = 1; i < 16; i++) begin
            en = 1'b1; wa = 5'(i); ld = 32'h1000 + 32'(i); step();
        end
        idle(); rsv = 1'b1; va = 5'd4; step();
        idle(); rst = 1'b1; en = 1'b1; wa = 5'd1; ld = 32'h7777; ra = 5'd1; rb = 5'd4; step();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("lit_rst_a%0d", k), dut_a[k], 32'h0);
            chk($sformatf("lit_rst_busy%0d", k), 32'(dbb[k]), 32'h0);
        end
        idle();
        for (int i = 0; i < 32; i++) begin
            ra = 5'(i); rb = 5'((i + 3) % 32); step();
            if (i == 1) chk("lit_rst_r1_a1", dut_a[1], 32'h0);
            if (i == 4) chk("lit_rst_r4_busy0", 32'(dba[0]), 32'h0);
        end

        // Wide configuration at the top register.
        en = 1'b1; wa = 5'd31; ld = 32'hDEADBEEF; step();
        idle(); ra = 5'd31; rb = 5'd31; step();
        chk("lit_wide_a3", dut_a[3], 32'hDEADBEEF);
        chk("lit_wide_b3", dut_b[3], 32'hDEADBEEF);
        chk("lit_wide_a0", dut_a[0], 32'hBEEF);

        // Random traffic, biased toward a few low registers to force collisions.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            en  = ($urandom_range(0, 1) == 1);
            rsv = ($urandom_range(0, 3) == 0);
            ld  = $urandom;
            wa  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            va  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            ra  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            rb  = 5'($urandom_range(0, 31));
            step();
        end
        idle(); step();
        @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
